// File: rtl/mix_pipe_pkg.sv
// mix_pipe_pkg: mode encoding and saturating add shared by the mix_pipe datapath.
package mix_pipe_pkg;
  typedef enum logic [1:0] {
    MODE_CUBE = 2'd0,
    MODE_XMIX = 2'd1,
    MODE_SUBS = 2'd2,
    MODE_ACC  = 2'd3
  } mode_e;
  localparam int MAX_W = 32;
  // Returns {overflow, result}; result is clamped to 2^w-1 and valid in its low w bits.
  function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] acc, input logic [MAX_W-1:0] inc, input int unsigned w);
    logic [MAX_W:0] sum;
    logic [MAX_W:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = ({{MAX_W{1'b0}}, 1'b1} << w) - (MAX_W + 1)'(1);
    return {sum > lim, (sum > lim) ? lim[MAX_W-1:0] : sum[MAX_W-1:0]};
  endfunction
endpackage

// File: rtl/mix_pipe_if.sv
// mix_pipe_if: valid/ready sample input and result output of mix_pipe.
interface mix_pipe_if import mix_pipe_pkg::*; #(parameter int DATA_W = 4, parameter int OUT_W = 10);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  mode_e in_mode;
  logic out_valid;
  logic out_ready;
  logic [OUT_W-1:0] out_data;
  mode_e out_mode;
  modport master(output in_valid, in_data, in_mode, out_ready, input in_ready, out_valid, out_data, out_mode);
  modport slave(input in_valid, in_data, in_mode, out_ready, output in_ready, out_valid, out_data, out_mode);
endinterface

// File: rtl/mix_pipe_func.sv
// mix_pipe_func: combinational CUBE/XMIX/SUBS functions, all modulo 2^OUT_W.
module mix_pipe_func import mix_pipe_pkg::*; #(
  parameter int DATA_W = 4,
  parameter int OUT_W = 10
) (
  input  logic [DATA_W-1:0]   i_a,
  input  logic [2*DATA_W-1:0] i_sq,
  input  mode_e               i_mode,
  output logic [OUT_W-1:0]    o_res
);
  logic [DATA_W-1:0] w_na;
  logic [OUT_W-1:0] w_cube;
  logic [OUT_W-1:0] w_xmix;
  logic [OUT_W-1:0] w_subs;
  assign w_na = ~i_a;
  // Working mod 2^OUT_W keeps the low bits of the full-width products exact.
  assign w_cube = OUT_W'(i_sq) * OUT_W'(i_a);
  assign w_xmix = OUT_W'(i_sq) ^ OUT_W'(w_na);
  assign w_subs = OUT_W'(i_sq) - OUT_W'(i_a);
  always_comb
    o_res = i_mode == MODE_CUBE ? w_cube :
            i_mode == MODE_XMIX ? w_xmix :
            i_mode == MODE_SUBS ? w_subs : '0;
endmodule

// File: rtl/mix_pipe.sv
// mix_pipe: two-stage valid/ready pipeline applying a per-sample mode function,
// with a saturating accumulator for MODE_ACC and a wrapping accepted-sample counter.
module mix_pipe import mix_pipe_pkg::*; #(
  parameter int DATA_W = 4,
  parameter int OUT_W = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  mix_pipe_if.slave        bus,
  input  logic             acc_clear,
  output logic             acc_sat,
  output logic [CNT_W-1:0] sample_count
);
  localparam int SQ_W = 2 * DATA_W;
  logic w_adv;
  logic w_accept;
  logic w_acc_upd;
  logic w_unused;
  logic r_s1_v;
  logic r_s2_v;
  logic r_sat;
  logic [DATA_W-1:0] r_s1_a;
  logic [SQ_W-1:0] r_s1_sq;
  mode_e r_s1_mode;
  mode_e r_s2_mode;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] r_s2_data;
  logic [OUT_W-1:0] w_acc_base;
  logic [OUT_W-1:0] w_func;
  logic [OUT_W-1:0] w_res;
  logic [MAX_W:0] w_sum;
  logic [CNT_W-1:0] r_cnt;
  assign w_adv = ~r_s2_v | bus.out_ready;
  assign w_accept = bus.in_valid & w_adv;
  assign w_acc_upd = w_adv & r_s1_v & (r_s1_mode == MODE_ACC);
  // A clear in the same cycle as an ACC transfer takes effect before the add.
  assign w_acc_base = acc_clear ? '0 : r_acc;
  assign w_sum = sat_add(MAX_W'(w_acc_base), MAX_W'(r_s1_sq), OUT_W);
  assign w_unused = ^w_sum[MAX_W-1:OUT_W];
  assign w_res = r_s1_mode == MODE_ACC ? w_sum[OUT_W-1:0] : w_func;
  mix_pipe_func #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_func (
    .i_a    (r_s1_a),
    .i_sq   (r_s1_sq),
    .i_mode (r_s1_mode),
    .o_res  (w_func)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_a    <= '0;
      r_s1_sq   <= '0;
      r_s1_mode <= MODE_CUBE;
      r_s2_v    <= 1'b0;
      r_s2_data <= '0;
      r_s2_mode <= MODE_CUBE;
    end else if (w_adv) begin
      r_s1_v    <= bus.in_valid;
      r_s1_a    <= bus.in_data;
      r_s1_sq   <= SQ_W'(bus.in_data) * SQ_W'(bus.in_data);
      r_s1_mode <= bus.in_mode;
      r_s2_v    <= r_s1_v;
      r_s2_data <= w_res;
      r_s2_mode <= r_s1_mode;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_acc <= '0;
      r_sat <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_acc <= w_acc_upd ? w_sum[OUT_W-1:0] : w_acc_base;
      r_sat <= (~acc_clear & r_sat) | (w_acc_upd & w_sum[MAX_W]);
      r_cnt <= r_cnt + CNT_W'(w_accept);
    end
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_s2_v;
  assign bus.out_data  = r_s2_data;
  assign bus.out_mode  = r_s2_mode;
  assign acc_sat       = r_sat;
  assign sample_count  = r_cnt;
endmodule
